// File: rtl/ikaopll_pkg.sv
// Shared constants and table helpers for the phase generator.
package ikaopll_pkg;
  localparam int NSLOT   = 18;
  localparam int PHASE_W = 19;
  localparam int INC_W   = 20;
  localparam logic [4:0] LAST_SLOT = 5'(NSLOT - 1);

  // Doubled multiplier table; the half-step code 0 (x0.5) becomes 1.
  function automatic logic [4:0] mul2_lut(input logic [3:0] mul);
    logic [4:0] r;
    case (mul)
      4'd0:  r = 5'd1;
      4'd1:  r = 5'd2;
      4'd2:  r = 5'd4;
      4'd3:  r = 5'd6;
      4'd4:  r = 5'd8;
      4'd5:  r = 5'd10;
      4'd6:  r = 5'd12;
      4'd7:  r = 5'd14;
      4'd8:  r = 5'd16;
      4'd9:  r = 5'd18;
      4'd10: r = 5'd20;
      4'd11: r = 5'd20;
      4'd12: r = 5'd24;
      4'd13: r = 5'd24;
      4'd14: r = 5'd30;
      default: r = 5'd30;
    endcase
    return r;
  endfunction

  // Vibrato magnitude taken from the top F-number bits.
  function automatic logic [2:0] pm_offset(input logic [8:0] fnum, input logic pm_en,
                                           input logic [1:0] pm_sel);
    logic [2:0] r;
    if (!pm_en || pm_sel == 2'd0) r = 3'd0;
    else if (pm_sel[0])           r = {1'b0, fnum[8:7]};
    else                          r = fnum[8:6];
    return r;
  endfunction
endpackage

// File: rtl/ikaopll_pg_inc.sv
// Combinational phase increment: FNUM + vibrato, octave shift, multiplier.
module ikaopll_pg_inc
  import ikaopll_pkg::*;
(
  input  logic [8:0]       i_fnum,
  input  logic [2:0]       i_block,
  input  logic [3:0]       i_mul,
  input  logic             i_pm_en,
  input  logic [2:0]       i_pmval,
  output logic [INC_W-1:0] o_inc
);
  logic [2:0]  m;
  logic [9:0]  f;
  logic [16:0] shl;
  logic [15:0] b;
  logic [20:0] prod;

  // PM offset applied to FNUM, then block shift and multiplier scaling.
  always_comb begin
    m    = pm_offset(i_fnum, i_pm_en, i_pmval[1:0]);
    // m never exceeds FNUM, so the subtract cannot wrap.
    f    = i_pmval[2] ? ({1'b0, i_fnum} - {7'd0, m}) : ({1'b0, i_fnum} + {7'd0, m});
    shl  = {7'd0, f} << i_block;
    b    = 16'(shl >> 1);
    prod = {5'd0, b} * {16'd0, mul2_lut(i_mul)};
    o_inc = INC_W'(prod >> 1);
  end
endmodule

// File: rtl/ikaopll_pg.sv
// Phase generator: slot counter, increment pipeline, 18-entry rotating accumulators.
module ikaopll_pg
  import ikaopll_pkg::*;
(
  input  logic       i_EMUCLK,
  input  logic       i_RST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_00,
  input  logic [3:0] i_TEST,
  input  logic [8:0] i_FNUM,
  input  logic [2:0] i_BLOCK,
  input  logic [3:0] i_MUL,
  input  logic       i_PM_EN,
  input  logic [2:0] i_PMVAL,
  input  logic       i_PG_RST,
  output logic [9:0] o_PHASE,
  output logic [4:0] o_SLOT
);
  logic tick;
  assign tick = ~i_phi1_NCEN_n;

  logic unused_test;
  assign unused_test = ^{i_TEST[3], i_TEST[1:0]};

  logic [INC_W-1:0]   inc_w;
  logic [4:0]         slot_q, slot_d;
  logic [INC_W-1:0]   inc_q, inc_d;
  logic               rst_q, rst_d;
  logic [PHASE_W-1:0] acc_q [NSLOT];
  logic [PHASE_W-1:0] acc_d [NSLOT];
  logic [9:0]         phase_q, phase_d;
  logic [4:0]         oslot_q, oslot_d;

  ikaopll_pg_inc u_inc (
    .i_fnum  (i_FNUM),
    .i_block (i_BLOCK),
    .i_mul   (i_MUL),
    .i_pm_en (i_PM_EN),
    .i_pmval (i_PMVAL),
    .o_inc   (inc_w)
  );

  // Stage 1: slot counter (doubles as the stage-1 slot tag), registered inc and key-on reset.
  always_comb begin
    slot_d = slot_q;
    inc_d  = inc_q;
    rst_d  = rst_q;
    if (tick) begin
      if (i_CYCLE_00 || slot_q == LAST_SLOT) slot_d = '0;
      else                                   slot_d = slot_q + 5'd1;
      inc_d = inc_w;
      rst_d = i_PG_RST;
    end
  end

  // Stage 2: rotate storage, head is this slot's phase; updated value goes to the tail.
  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    oslot_d = oslot_q;
    if (tick) begin
      for (int i = 0; i < NSLOT - 1; i++) acc_d[i] = acc_q[i+1];
      acc_d[NSLOT-1] = (rst_q || i_TEST[2]) ? '0
                     : PHASE_W'({1'b0, acc_q[0]} + inc_q);
      phase_d = acc_q[0][PHASE_W-1 -: 10];
      oslot_d = slot_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      slot_q  <= '0;
      inc_q   <= '0;
      rst_q   <= 1'b0;
      phase_q <= '0;
      oslot_q <= '0;
      for (int i = 0; i < NSLOT; i++) acc_q[i] <= '0;
    end else begin
      slot_q  <= slot_d;
      inc_q   <= inc_d;
      rst_q   <= rst_d;
      phase_q <= phase_d;
      oslot_q <= oslot_d;
      for (int i = 0; i < NSLOT; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign o_PHASE = phase_q;
  assign o_SLOT  = oslot_q;
endmodule

// File: tb/tb_ikaopll_pg.sv
// Bench for ikaopll_pg: per-slot phase model, negedge compare, literal spot checks.
module tb_ikaopll_pg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_phi1_NCEN_n = 1'b1;
  logic       i_CYCLE_00 = 1'b0;
  logic [3:0] i_TEST = '0;
  logic [8:0] i_FNUM = '0;
  logic [2:0] i_BLOCK = '0;
  logic [3:0] i_MUL = '0;
  logic       i_PM_EN = 1'b0;
  logic [2:0] i_PMVAL = '0;
  logic       i_PG_RST = 1'b0;
  logic [9:0] o_PHASE;
  logic [4:0] o_SLOT;

  always #5 clk = ~clk;

  ikaopll_pg dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phi1_NCEN_n(i_phi1_NCEN_n),
    .i_CYCLE_00(i_CYCLE_00), .i_TEST(i_TEST), .i_FNUM(i_FNUM), .i_BLOCK(i_BLOCK),
    .i_MUL(i_MUL), .i_PM_EN(i_PM_EN), .i_PMVAL(i_PMVAL), .i_PG_RST(i_PG_RST),
    .o_PHASE(o_PHASE), .o_SLOT(o_SLOT)
  );

  int checks = 0;
  int errors = 0;
  int mul2_t[16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

  // Per-slot configuration (indexed by slot number) and global inputs.
  int fnum_c[18], blk_c[18], mul_c[18], pmen_c[18], pgrst_c[18];
  int pmval = 0;

  // Model: one phase per slot number, plus the item waiting in the pipeline.
  int unsigned acc_m[18];
  int pend_slot = 0, pend_inc = 0, pend_rst = 0;
  int exp_phase = 0, exp_slot = 0;
  bit cmp_en = 1'b0;
  int cap[18];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  function automatic int model_inc(input int fnum, input int blk, input int mul,
                                   input int pm_en, input int pv);
    int m, f, b;
    m = 0;
    if (pm_en != 0 && (pv % 4) != 0) m = ((pv % 4) == 2) ? fnum / 64 : fnum / 128;
    f = (pv >= 4) ? fnum - m : fnum + m;
    b = ((f * (1 << blk)) / 2) % 65536;
    return (b * mul2_t[mul]) / 2;
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < 18; i++) begin
      fnum_c[i] = 0; blk_c[i] = 0; mul_c[i] = 0; pmen_c[i] = 0; pgrst_c[i] = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 18; i++) acc_m[i] = 0;
    pend_slot = 0; pend_inc = 0; pend_rst = 0;
    exp_phase = 0; exp_slot = 0;
  endtask

  // One enabled tick presenting slot s; the model retires the previously presented slot.
  task automatic tick(input int s);
    i_phi1_NCEN_n = 1'b0;
    i_CYCLE_00 = (s == 0);
    i_FNUM   = 9'(fnum_c[s]);
    i_BLOCK  = 3'(blk_c[s]);
    i_MUL    = 4'(mul_c[s]);
    i_PM_EN  = (pmen_c[s] != 0);
    i_PMVAL  = 3'(pmval);
    i_PG_RST = (pgrst_c[s] != 0);
    @(posedge clk);
    exp_slot  = pend_slot;
    exp_phase = int'(acc_m[pend_slot] >> 9);
    if (pend_rst != 0 || i_TEST[2]) acc_m[pend_slot] = 0;
    else acc_m[pend_slot] = (acc_m[pend_slot] + pend_inc) % 524288;
    pend_slot = s;
    pend_inc  = model_inc(fnum_c[s], blk_c[s], mul_c[s], pmen_c[s], pmval);
    pend_rst  = pgrst_c[s];
    #1;
  endtask

  // Full frame; cap[k] holds the phase the DUT reported for slot k (0..16).
  task automatic run_frame();
    for (int s = 0; s < 18; s++) begin
      tick(s);
      if (s > 0) cap[s-1] = int'(o_PHASE);
    end
  endtask

  task automatic idle(input int n);
    i_phi1_NCEN_n = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Continuous compare of both outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("phase", int'(o_PHASE), exp_phase);
      check("slot", int'(o_SLOT), exp_slot);
    end
  end

  initial begin
    clear_cfg();
    model_reset();
    // Pin the model's increment arithmetic to hand-computed values.
    check("m_inc_2048", model_inc(256, 4, 1, 0, 0), 2048);
    check("m_inc_pm2", model_inc(448, 1, 1, 1, 2), 455);
    check("m_inc_pm6", model_inc(448, 1, 1, 1, 6), 441);
    check("m_inc_pm1", model_inc(448, 1, 1, 1, 1), 451);
    check("m_inc_pm4", model_inc(448, 1, 1, 1, 4), 448);
    check("m_inc_mul0", model_inc(256, 1, 0, 0, 0), 128);
    check("m_inc_mul15", model_inc(256, 1, 15, 0, 0), 3840);

    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    #20 rst_n = 1'b1;
    check("rst_phase", int'(o_PHASE), 0);
    check("rst_slot", int'(o_SLOT), 0);

    // First frame after reset: everything zero.
    run_frame();

    // Slot 3 at inc 2048: phase steps by 4 per frame and wraps after 256 frames.
    fnum_c[3] = 256; blk_c[3] = 4; mul_c[3] = 1;
    run_frame();
    check("s3_f1", cap[3], 0);
    run_frame();
    check("s3_f2", cap[3], 4);
    for (int f = 3; f <= 128; f++) run_frame();
    run_frame();
    check("s3_f129", cap[3], 512);
    for (int f = 130; f <= 256; f++) run_frame();
    run_frame();
    check("s3_wrap", cap[3], 0);

    // Key-on reset on slot 5 only; neighbours keep counting.
    clear_cfg();
    for (int k = 4; k <= 6; k++) begin fnum_c[k] = 256; blk_c[k] = 4; mul_c[k] = 1; end
    repeat (3) run_frame();
    pgrst_c[5] = 1;
    run_frame();
    check("s5_pre_rst", cap[5], 12);
    pgrst_c[5] = 0;
    run_frame();
    check("s5_cleared", cap[5], 0);
    check("s4_keeps", cap[4], 16);
    check("s6_keeps", cap[6], 16);

    // Vibrato across all PM steps, plus MUL extremes and max-width increment.
    clear_cfg();
    for (int k = 0; k <= 3; k++) begin fnum_c[k] = 448; blk_c[k] = 1; mul_c[k] = 1; pmen_c[k] = 1; end
    pmen_c[2] = 0;
    fnum_c[7] = 256; blk_c[7] = 1; mul_c[7] = 0;
    fnum_c[8] = 256; blk_c[8] = 1; mul_c[8] = 15;
    fnum_c[9] = 511; blk_c[9] = 7; mul_c[9] = 15; pmen_c[9] = 1;
    fnum_c[10] = 1; blk_c[10] = 0; mul_c[10] = 0;
    foreach (mul2_t[i]) if (i < 8) begin
      pmval = (i == 0) ? 2 : (i == 1) ? 6 : (i == 2) ? 1 : (i == 3) ? 4 : i;
      repeat (3) run_frame();
    end
    // PM step changing on every tick.
    for (int s = 0; s < 18; s++) begin pmval = s % 8; tick(s); end
    pmval = 2;

    // Disabled edges in mid-frame must not move anything.
    for (int s = 0; s < 6; s++) tick(s);
    idle(5);
    for (int s = 6; s < 18; s++) tick(s);
    run_frame();

    // Test-register phase clear for two frames, then resume.
    i_TEST = 4'b0100;
    repeat (2) run_frame();
    i_TEST = 4'b1011;
    repeat (3) run_frame();
    i_TEST = 4'b0000;

    // Asynchronous reset mid-frame.
    for (int s = 0; s < 9; s++) tick(s);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_phase", int'(o_PHASE), 0);
    check("mid_rst_slot", int'(o_SLOT), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) run_frame();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
